// File: rtl/conv_pkg.sv
// Shared constants and the responder state type for the CONV layer memory responder.
package conv_pkg;

  localparam int DATA_W    = 20;
  localparam int IMG_DEPTH = 4096;
  localparam int L0_DEPTH  = 4096;
  localparam int L1_DEPTH  = 1024;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    RUN,
    DRAIN,
    DONE
  } resp_state_e;

endpackage

// File: rtl/conv_bank.sv
// Word-wide memory bank: one synchronous write port, NRP combinational read ports.
module conv_bank #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRP   = 1
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [NRP*AW-1:0]    raddr_i,
  output logic [NRP*WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Reads see the array before this edge's write, so same-address read returns old data.
  for (genvar p = 0; p < NRP; p++) begin : gen_rd
    assign rdata_o[p*WIDTH +: WIDTH] = mem[raddr_i[p*AW +: AW]];
  end

endmodule

// File: rtl/conv_mem_responder.sv
// Image/L0/L1 storage for the CONV engine plus the host load, start handshake and result drain.
module conv_mem_responder
  import conv_pkg::resp_state_e, conv_pkg::IDLE, conv_pkg::KICK, conv_pkg::RUN,
         conv_pkg::DRAIN, conv_pkg::DONE, conv_pkg::CSEL_L0, conv_pkg::CSEL_L1,
         conv_pkg::IMG_DEPTH, conv_pkg::L0_DEPTH, conv_pkg::L1_DEPTH;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_AW = 12,
  parameter int L1_AW  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  input  logic [2:0]        csel,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              done
);

  resp_state_e state_q, state_d;
  logic [IMG_AW-1:0] ldPtr_q, ldPtr_d;
  logic [L1_AW-1:0]  drPtr_q, drPtr_d;
  logic              loaded_q, loaded_d;
  logic              busyPrev_q;
  logic              imgWe, l0We, l1We;
  logic [DATA_W-1:0] l0Rdata;
  logic [DATA_W-1:0] l1EngRdata, l1DrainRdata;
  logic              unusedRdHi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ldPtr_q    <= '0;
      drPtr_q    <= '0;
      loaded_q   <= 1'b0;
      busyPrev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ldPtr_q    <= ldPtr_d;
      drPtr_q    <= drPtr_d;
      loaded_q   <= loaded_d;
      busyPrev_q <= busy;
    end
  end

  always_comb begin
    state_d  = state_q;
    ldPtr_d  = ldPtr_q;
    drPtr_d  = drPtr_q;
    loaded_d = loaded_q;
    imgWe    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_valid && !loaded_q) begin
          imgWe   = 1'b1;
          ldPtr_d = ldPtr_q + 1'b1;
          if (ldPtr_q == '1) begin
            loaded_d = 1'b1;
          end
        end
        if (start && loaded_q) begin
          state_d = KICK;
        end
      end
      KICK: begin
        if (busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (busyPrev_q && !busy) begin
          state_d = DRAIN;
          drPtr_d = '0;
        end
      end
      DRAIN: begin
        if (rd_ready) begin
          drPtr_d = drPtr_q + 1'b1;
          if (drPtr_q == '1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        loaded_d = 1'b0;
        ldPtr_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q == KICK);
  assign rd_valid = (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign rd_data  = rd_valid ? l1DrainRdata : '0;

  // L1 writes whose address overflows the 1024-word bank are dropped, not aliased.
  assign l0We = cwr && (csel == CSEL_L0);
  assign l1We = cwr && (csel == CSEL_L1) && (caddr_wr[IMG_AW-1:L1_AW] == '0);

  always_comb begin
    cdata_rd = '0;
    if (crd && (csel == CSEL_L0)) begin
      cdata_rd = l0Rdata;
    end else if (crd && (csel == CSEL_L1)) begin
      cdata_rd = l1EngRdata;
    end
  end

  assign unusedRdHi = ^caddr_rd[IMG_AW-1:L1_AW];

  conv_bank #(.WIDTH(DATA_W), .DEPTH(IMG_DEPTH), .AW(IMG_AW), .NRP(1)) u_img (
    .clk     (clk),
    .we_i    (imgWe),
    .waddr_i (ldPtr_q),
    .wdata_i (ld_data),
    .raddr_i (iaddr),
    .rdata_o (idata)
  );

  conv_bank #(.WIDTH(DATA_W), .DEPTH(L0_DEPTH), .AW(IMG_AW), .NRP(1)) u_l0 (
    .clk     (clk),
    .we_i    (l0We),
    .waddr_i (caddr_wr),
    .wdata_i (cdata_wr),
    .raddr_i (caddr_rd),
    .rdata_o (l0Rdata)
  );

  // Port 0 serves the engine, port 1 feeds the host drain stream.
  conv_bank #(.WIDTH(DATA_W), .DEPTH(L1_DEPTH), .AW(L1_AW), .NRP(2)) u_l1 (
    .clk     (clk),
    .we_i    (l1We),
    .waddr_i (caddr_wr[L1_AW-1:0]),
    .wdata_i (cdata_wr),
    .raddr_i ({drPtr_q, caddr_rd[L1_AW-1:0]}),
    .rdata_o ({l1DrainRdata, l1EngRdata})
  );

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized self-checking bench for conv_mem_responder against a behavioural memory/handshake model.
module tb_conv_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [19:0] ld_data = '0;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [2:0]  csel = '0;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [19:0] cdata_wr = '0;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic        rd_ready = 1'b0;
  logic        ready, rd_valid, done;
  logic [19:0] idata, cdata_rd, rd_data;

  int nCompared = 0;
  int nMismatched = 0;

  logic [19:0] imgModel [4096];
  logic [19:0] l0Model  [4096];
  logic [19:0] l1Model  [1024];

  conv_mem_responder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .start    (start),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .csel     (csel),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Loads words [first..last] with random ld_valid gaps; ramp or random data.
  task automatic loadRange(input int first, input int last, input bit useRamp);
    int n;
    n = first;
    while (n <= last) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = useRamp ? 20'(n) : 20'($urandom);
      if (ld_valid) imgModel[n] = ld_data;
      tick();
      if (ld_valid) n++;
    end
    ld_valid = 1'b0;
  endtask

  task automatic engineWrite(input logic [2:0] sel, input int addr, input logic [19:0] data);
    cwr = 1'b1; csel = sel; caddr_wr = 12'(addr); cdata_wr = data;
    if (sel == 3'b001) l0Model[addr] = data;
    else if (sel == 3'b011 && addr < 1024) l1Model[addr] = data;
    tick();
    cwr = 1'b0;
  endtask

  task automatic engineRead(input logic [2:0] sel, input int addr, input logic doRead);
    crd = doRead; csel = sel; caddr_rd = 12'(addr);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nCompared++; if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    nCompared++; if (rd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    nCompared++; if (rd_data !== 20'h0) begin nMismatched++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data); end
    reset_n = 1'b1;
    tick();
    nCompared++; if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_ready: got %b expected 0", ready); end
  endtask

  task automatic test_start_unloaded();
    loadRange(0, 99, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nCompared++; if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL early_start_ready: got %b expected 0 (cycle %0d)", ready, i); end
      tick();
    end
    loadRange(100, 4095, 1'b1);
    // extra words after a full image must not land anywhere
    ld_valid = 1'b1; ld_data = 20'hFFFFF;
    repeat (3) tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_image_read();
    int a;
    iaddr = 12'h0FF; #1;
    nCompared++; if (idata !== 20'h000FF) begin nMismatched++; $display("[TB] FAIL idata_0ff: got %h expected 000FF", idata); end
    iaddr = 12'h000; #1;
    nCompared++; if (idata !== imgModel[0]) begin nMismatched++; $display("[TB] FAIL idata_first: got %h expected %h", idata, imgModel[0]); end
    iaddr = 12'hFFF; #1;
    nCompared++; if (idata !== imgModel[4095]) begin nMismatched++; $display("[TB] FAIL idata_last: got %h expected %h", idata, imgModel[4095]); end
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, 4095);
      iaddr = 12'(a); #1;
      nCompared++; if (idata !== imgModel[a]) begin nMismatched++; $display("[TB] FAIL idata_rand: addr %0d got %h expected %h", a, idata, imgModel[a]); end
    end
    tick();
  endtask

  task automatic test_engine_ports();
    engineWrite(3'b001, 100, 20'hABCDE);
    engineRead(3'b001, 100, 1'b1);
    nCompared++; if (cdata_rd !== 20'hABCDE) begin nMismatched++; $display("[TB] FAIL l0_wr_rd: got %h expected ABCDE", cdata_rd); end
    tick();
    engineWrite(3'b011, 100, 20'hABCDE);
    engineRead(3'b011, 100, 1'b1);
    nCompared++; if (cdata_rd !== 20'hABCDE) begin nMismatched++; $display("[TB] FAIL l1_wr_rd: got %h expected ABCDE", cdata_rd); end
    tick();
    engineWrite(3'b001, 200, 20'h12345);
    engineWrite(3'b000, 200, 20'h54321);
    engineRead(3'b001, 200, 1'b1);
    nCompared++; if (cdata_rd !== l0Model[200]) begin nMismatched++; $display("[TB] FAIL csel0_no_write: got %h expected %h", cdata_rd, l0Model[200]); end
    engineRead(3'b000, 200, 1'b1);
    nCompared++; if (cdata_rd !== 20'h0) begin nMismatched++; $display("[TB] FAIL csel0_read: got %h expected 0", cdata_rd); end
    engineRead(3'b001, 200, 1'b0);
    nCompared++; if (cdata_rd !== 20'h0) begin nMismatched++; $display("[TB] FAIL crd_low_read: got %h expected 0", cdata_rd); end
    crd = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle_and_drop();
    engineWrite(3'b011, 5, 20'h11111);
    cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd5; cdata_wr = 20'h22222;
    crd = 1'b1; caddr_rd = 12'd5; #1;
    nCompared++; if (cdata_rd !== 20'h11111) begin nMismatched++; $display("[TB] FAIL same_cycle_old: got %h expected 11111", cdata_rd); end
    l1Model[5] = 20'h22222;
    tick();
    cwr = 1'b0; #1;
    nCompared++; if (cdata_rd !== 20'h22222) begin nMismatched++; $display("[TB] FAIL same_cycle_new: got %h expected 22222", cdata_rd); end
    crd = 1'b0;
    engineWrite(3'b011, 6, 20'h33333);
    engineWrite(3'b011, 1030, 20'h44444);
    engineRead(3'b011, 6, 1'b1);
    nCompared++; if (cdata_rd !== 20'h33333) begin nMismatched++; $display("[TB] FAIL l1_oob_drop: got %h expected 33333", cdata_rd); end
    crd = 1'b0;
    tick();
  endtask

  task automatic test_random_engine();
    int pool [8] = '{7, 100, 512, 1023, 1024, 2047, 3000, 4095};
    int wa, ra;
    logic [19:0] expData;
    for (int i = 0; i < 8; i++) begin
      engineWrite(3'b001, pool[i], 20'($urandom));
      engineWrite(3'b011, pool[i] % 1024, 20'($urandom));
    end
    for (int i = 0; i < 60; i++) begin
      wa = pool[$urandom_range(0, 7)];
      ra = pool[$urandom_range(0, 7)];
      cwr = 1'($urandom); crd = 1'($urandom); csel = 3'($urandom_range(0, 7));
      caddr_wr = 12'(wa); caddr_rd = 12'(ra); cdata_wr = 20'($urandom);
      expData = 20'h0;
      if (crd && csel == 3'b001) expData = l0Model[ra];
      else if (crd && csel == 3'b011) expData = l1Model[ra % 1024];
      #1;
      nCompared++; if (cdata_rd !== expData) begin nMismatched++; $display("[TB] FAIL rand_engine: iter %0d csel %b rd %0d got %h expected %h", i, csel, ra, cdata_rd, expData); end
      if (cwr && csel == 3'b001) l0Model[wa] = cdata_wr;
      else if (cwr && csel == 3'b011 && wa < 1024) l1Model[wa] = cdata_wr;
      tick();
    end
    cwr = 1'b0; crd = 1'b0;
  endtask

  task automatic test_handshake();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nCompared++; if (ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL kick_ready: got %b expected 1 (cycle %0d)", ready, i); end
      tick();
    end
    busy = 1'b1;
    tick();
    nCompared++; if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL ready_drop: got %b expected 0", ready); end
    for (int i = 0; i < 1024; i++) engineWrite(3'b011, i, 20'(3 * i));
    nCompared++; if (rd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL run_rd_valid: got %b expected 0", rd_valid); end
  endtask

  task automatic test_drain();
    int idx, cycles, donePulses;
    idx = 0; cycles = 0; donePulses = 0;
    busy = 1'b0;
    tick();
    while (idx < 1024 && cycles < 5000) begin
      nCompared++; if (rd_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL drain_valid: word %0d got %b expected 1", idx, rd_valid); end
      nCompared++; if (rd_data !== l1Model[idx]) begin nMismatched++; $display("[TB] FAIL drain_data: word %0d got %h expected %h", idx, rd_data, l1Model[idx]); end
      if (done) donePulses++;
      rd_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      if (rd_ready) idx++;
      @(negedge clk);
      cycles++;
    end
    rd_ready = 1'b0;
    nCompared++; if (idx != 1024) begin nMismatched++; $display("[TB] FAIL drain_timeout: got %0d words expected 1024", idx); end
    nCompared++; if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL done_pulse: got %b expected 1", done); end
    if (done) donePulses++;
    nCompared++; if (rd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL done_rd_valid: got %b expected 0", rd_valid); end
    tick();
    if (done) donePulses++;
    nCompared++; if (donePulses != 1) begin nMismatched++; $display("[TB] FAIL done_count: got %0d expected 1", donePulses); end
  endtask

  task automatic test_reset_mid_drain();
    int idx, cycles;
    loadRange(0, 4095, 1'b0);
    for (int i = 0; i < 4; i++) begin
      iaddr = 12'($urandom_range(0, 4095)); #1;
      nCompared++; if (idata !== imgModel[iaddr]) begin nMismatched++; $display("[TB] FAIL reload_idata: addr %0d got %h expected %h", iaddr, idata, imgModel[iaddr]); end
    end
    tick();
    start = 1'b1; tick(); start = 1'b0;
    busy = 1'b1; tick();
    busy = 1'b0; tick();
    idx = 0; cycles = 0;
    rd_ready = 1'b1;
    while (idx < 500 && cycles < 2000) begin
      if (idx % 100 == 0) begin
        nCompared++; if (rd_data !== l1Model[idx]) begin nMismatched++; $display("[TB] FAIL drain2_data: word %0d got %h expected %h", idx, rd_data, l1Model[idx]); end
      end
      @(posedge clk);
      if (rd_valid) idx++;
      @(negedge clk);
      cycles++;
    end
    rd_ready = 1'b0;
    nCompared++; if (idx != 500) begin nMismatched++; $display("[TB] FAIL drain2_timeout: got %0d words expected 500", idx); end
    reset_n = 1'b0;
    #1;
    nCompared++; if (rd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_rd_valid: got %b expected 0", rd_valid); end
    nCompared++; if (rd_data !== 20'h0) begin nMismatched++; $display("[TB] FAIL abort_rd_data: got %h expected 0", rd_data); end
    tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nCompared++; if (ready !== 1'b0 || rd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL restart_ignored: ready %b rd_valid %b expected 0 0", ready, rd_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_start_unloaded();
    test_image_read();
    test_engine_ports();
    test_same_cycle_and_drop();
    test_random_engine();
    test_handshake();
    test_drain();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
